mips_cpu_regfile_write_arbiter: RTL and testbench
=================================================

MIPS_CPU_REGFILE_WRITE_ARBITER -- requirements
Module: mips_cpu_regfile_write_arbiter

Interface
REQ-001 Parameter: NREQ, 3, number of write-back requesters (0 = ALU, 1 = load unit, 2 = link/JAL).
REQ-002 Parameter: DATA_W, 32, write data width.
REQ-003 The block SHALL use exactly one clock and one reset: reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester write request.
REQ-007 req_reg  input  NREQ x 5  per-requester destination register.
REQ-008 req_data  input  NREQ x DATA_W  per-requester write data.
REQ-009 req_ready  output  NREQ  per-requester grant; transfer occurs when valid && ready.
REQ-010 rsv_valid  input  1  reserve destination register of an issued instruction.
REQ-011 rsv_reg  input  5  register to reserve.
REQ-012 wr_enable  output  1  register-file write enable.
REQ-013 wr_reg  output  5  register-file write address.
REQ-014 wr_data  output  DATA_W  register-file write data.
REQ-015 busy  output  32  scoreboard; bit n = register n has a pending write.

Function
REQ-016 The block SHALL grant at most one requester per cycle; req_ready SHALL be combinational from req_valid and rr_ptr.
REQ-017 The arbiter SHALL be round-robin: search starts at rr_ptr and wraps from NREQ-1 to 0; the first valid requester wins.
REQ-018 On a transfer by requester k, rr_ptr SHALL become (k+1) mod NREQ at the next edge; with no transfer, rr_ptr SHALL hold.
REQ-019 req_ready SHALL be 0 for every requester when no req_valid is set.
REQ-020 A granted transfer SHALL register wr_reg/wr_data at the next edge, so there is 1-cycle latency from handshake to wr_enable.
REQ-021 wr_enable SHALL be 1 for exactly one cycle per transfer, and 0 when there is no transfer or when req_reg = 0; a request to register 0 SHALL still be granted (consumed).
REQ-022 rsv_valid with rsv_reg != 0 SHALL set busy[rsv_reg] at the next edge; rsv_reg = 0 SHALL be ignored.
REQ-023 A transfer to register r SHALL clear busy[r] at the same edge that wr_enable is registered.
REQ-024 If a reserve and a transfer address the same register in the same cycle, the set SHALL win and busy SHALL stay 1.
REQ-025 Reserving an already-busy register SHALL leave it busy (no counting); a transfer to a non-busy register SHALL be legal and leave it 0.
REQ-026 A requester holding valid without ready SHALL keep its reg/data stable; the block SHALL not drop or reorder its request.

Reset
REQ-027 While reset is high, wr_enable, wr_reg, wr_data, busy and rr_ptr SHALL be 0, and req_ready SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard any registered write; no wr_enable SHALL be produced for a handshake in the reset cycle.

Structure
REQ-029 Requester index constants (REQ_ALU, REQ_LOAD, REQ_LINK) and NREQ SHALL live in the shared CPU package.
REQ-030 The round-robin grant logic SHALL be a sub-module mips_cpu_rr_arbiter (inputs: valid vector and pointer; output: one-hot grant).

Verification
REQ-031 Single request: ALU valid, reg 5, data 0xDEADBEEF -> ready same cycle; next cycle wr_enable=1, wr_reg=5, wr_data=0xDEADBEEF; following cycle wr_enable=0.
REQ-032 Contention: all three valid continuously from reset -> grant order is 0,1,2,0,1,2, each one cycle apart.
REQ-033 Register zero: load requests reg 0 with data 0x1234 -> ready=1, wr_enable stays 0, and rr_ptr advances to 2.
REQ-034 Scoreboard: reserve reg 8 -> busy[8]=1; in the same cycle as an ALU write to reg 8, re-reserve reg 8 -> busy[8] stays 1; the next write to 8 with no reserve -> busy[8]=0.
REQ-035 Reset mid-transfer: assert reset in the handshake cycle for reg 3 -> wr_enable never pulses, and busy, rr_ptr and outputs are all 0.
REQ-036 Backpressure: requester 2 is held valid while 0 and 1 are also active -> requester 2 is granted within 3 cycles with unchanged data.

Source files
------------

// File: rtl/mips_cpu_regfile_write_arbiter_pkg.sv
// Shared CPU constants for register-file write-back: requester indices,
// default widths and the hard-wired zero register.
package mips_cpu_regfile_write_arbiter_pkg;

    localparam int NREQ     = 3;
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int NREGS    = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/mips_cpu_rr_arbiter.sv
// Round-robin grant: search starts at ptr, wraps at N-1, first valid wins.
module mips_cpu_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_write_arbiter.sv
// Register-file write-back arbiter: round-robin among ALU/load/link, one
// registered write per cycle, plus a pending-write scoreboard.
module mips_cpu_regfile_write_arbiter #(
    parameter int NREQ   = mips_cpu_regfile_write_arbiter_pkg::NREQ,
    parameter int DATA_W = mips_cpu_regfile_write_arbiter_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*5-1:0]      req_reg,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   rsv_valid,
    input  logic [4:0]             rsv_reg,
    output logic                   wr_enable,
    output logic [4:0]             wr_reg,
    output logic [DATA_W-1:0]      wr_data,
    output logic [31:0]            busy
);

    import mips_cpu_regfile_write_arbiter_pkg::*;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [NREQ-1:0]   grant;
    logic              xfer;
    logic [4:0]        sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic [31:0]       busy_next;

    mips_cpu_rr_arbiter #(.N(NREQ), .PTR_W(PTR_W)) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Nothing is granted while reset is high, so no handshake can land in that cycle.
    assign req_ready = reset ? '0 : grant;
    assign xfer      = |req_ready;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        ptr_next = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) begin
                sel_reg  = req_reg[k*5 +: 5];
                sel_data = req_data[k*DATA_W +: DATA_W];
                ptr_next = (k == NREQ - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    // Clear first, then set, so a same-cycle reserve of the written register wins.
    always_comb begin
        busy_next = busy;
        if (xfer && sel_reg != REG_ZERO)
            busy_next[sel_reg] = 1'b0;
        if (rsv_valid && rsv_reg != REG_ZERO)
            busy_next[rsv_reg] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            wr_enable <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            busy      <= '0;
        end else begin
            rr_ptr    <= ptr_next;
            wr_enable <= xfer && (sel_reg != REG_ZERO);
            if (xfer) begin
                wr_reg  <= sel_reg;
                wr_data <= sel_data;
            end
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_mips_cpu_regfile_write_arbiter.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops and compares whenever a write is due or appears.
module tb_mips_cpu_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_reg;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_reg;
    logic        wr_enable;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [31:0] busy;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [4:0]  nxt_reg [3];
    logic [31:0] nxt_data[3];

    mips_cpu_regfile_write_arbiter #(.NREQ(3), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .wr_enable (wr_enable),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a queued write must appear exactly on its due cycle; any other pulse is spurious.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            checks++;
            if (wr_enable !== 1'b1 || wr_reg !== sbq[0].r || wr_data !== sbq[0].d) begin
                errors++;
                $display("FAIL write cyc=%0d: got en=%b reg=%0d data=%h want en=1 reg=%0d data=%h",
                         cyc, wr_enable, wr_reg, wr_data, sbq[0].r, sbq[0].d);
            end
            void'(sbq.pop_front());
        end else if (wr_enable !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write cyc=%0d: got en=%b reg=%0d data=%h want en=0",
                     cyc, wr_enable, wr_reg, wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic set_req(input int k, input logic [4:0] r, input logic [31:0] d);
        nxt_reg[k]  = r;
        nxt_data[k] = d;
    endtask

    // One cycle: apply inputs after the edge, check grant mid-cycle, queue the expected write.
    task automatic step(input logic [2:0] v, input logic [2:0] exp_rdy, input logic exp_wr,
                        input logic rv, input logic [4:0] rr);
        @(posedge clk);
        #1;
        req_valid = v;
        rsv_valid = rv;
        rsv_reg   = rr;
        for (int k = 0; k < 3; k++) begin
            req_reg[k*5 +: 5]    = nxt_reg[k];
            req_data[k*32 +: 32] = nxt_data[k];
        end
        @(negedge clk);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL ready cyc=%0d: got %b want %b (valid %b)", cyc, req_ready, exp_rdy, v);
        end
        if (exp_wr) begin
            for (int k = 0; k < 3; k++)
                if (exp_rdy[k]) sbq.push_back('{r: nxt_reg[k], d: nxt_data[k], due: cyc + 1});
        end
    endtask

    task automatic idle();
        step(3'b000, 3'b000, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 3'b111;
        req_reg   = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_reg   = '0;
        for (int k = 0; k < 3; k++) set_req(k, 5'd0, 32'd0);

        @(negedge clk);
        chk("reset_ready", {29'd0, req_ready}, 32'd0);
        chk("reset_wr_reg", {27'd0, wr_reg}, 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);
        chk("reset_busy", busy, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 3'b000;

        // Contention from reset: 0,1,2,0,1,2
        set_req(0, 5'd1,  32'hA000_0001);
        set_req(1, 5'd2,  32'hB000_0002);
        set_req(2, 5'd31, 32'hC000_001F);
        for (int n = 0; n < 2; n++) begin
            step(3'b111, 3'b001, 1'b1, 1'b0, 5'd0);
            step(3'b111, 3'b010, 1'b1, 1'b0, 5'd0);
            step(3'b111, 3'b100, 1'b1, 1'b0, 5'd0);
        end

        // Single ALU write, then no requests at all
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        step(3'b001, 3'b001, 1'b1, 1'b0, 5'd0);
        idle();
        idle();

        // Load to r0 is consumed without a write; pointer moves on to 2, so ALU beats load next
        set_req(1, 5'd0, 32'h0000_1234);
        step(3'b010, 3'b010, 1'b0, 1'b0, 5'd0);
        set_req(0, 5'd7, 32'h0000_0077);
        set_req(1, 5'd9, 32'h0000_0099);
        step(3'b011, 3'b001, 1'b1, 1'b0, 5'd0);
        idle();

        // Scoreboard: reserve twice, set beats clear, plain write clears, r0 reserve ignored
        step(3'b000, 3'b000, 1'b0, 1'b1, 5'd8);
        step(3'b000, 3'b000, 1'b0, 1'b1, 5'd8);
        chk("busy_after_reserve", busy, 32'h0000_0100);
        set_req(0, 5'd8, 32'h0000_0088);
        step(3'b001, 3'b001, 1'b1, 1'b1, 5'd8);
        idle();
        chk("busy_set_wins", busy, 32'h0000_0100);
        set_req(0, 5'd8, 32'h0000_0089);
        step(3'b001, 3'b001, 1'b1, 1'b0, 5'd0);
        idle();
        chk("busy_cleared", busy, 32'h0000_0000);
        step(3'b000, 3'b000, 1'b0, 1'b1, 5'd0);
        idle();
        chk("busy_r0_ignored", busy, 32'h0000_0000);

        // Backpressure: link held with stable data while ALU and load compete (pointer at 1)
        set_req(0, 5'd10, 32'h0000_00A0);
        set_req(1, 5'd11, 32'h0000_00B0);
        set_req(2, 5'd12, 32'h0000_00C0);
        step(3'b111, 3'b010, 1'b1, 1'b0, 5'd0);
        step(3'b111, 3'b100, 1'b1, 1'b0, 5'd0);
        step(3'b011, 3'b001, 1'b1, 1'b0, 5'd0);
        idle();

        // Reset in the handshake cycle of a write to r3
        set_req(1, 5'd13, 32'h0000_00D0);
        step(3'b010, 3'b010, 1'b1, 1'b0, 5'd0);
        step(3'b000, 3'b000, 1'b0, 1'b1, 5'd3);
        idle();
        chk("busy_r3_reserved", busy, 32'h0000_0008);
        set_req(0, 5'd3, 32'h0000_0033);
        step(3'b001, 3'b001, 1'b0, 1'b0, 5'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("ready_in_reset", {29'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        chk("midreset_busy", busy, 32'd0);
        chk("midreset_wr_reg", {27'd0, wr_reg}, 32'd0);
        chk("midreset_wr_data", wr_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Pointer is back at 0: load beats link
        set_req(1, 5'd14, 32'h0000_00E0);
        set_req(2, 5'd15, 32'h0000_00F0);
        step(3'b110, 3'b010, 1'b1, 1'b0, 5'd0);
        idle();
        idle();

        repeat (2) @(negedge clk);
        chk("queue_drained", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
